// File: rtl/aes_input_fifo.sv
// First-word-fall-through ingress FIFO feeding aes_controller with 128-bit packets.
// Holds the head entry until the controller pops it, so blocks wait out key expansion.
module aes_input_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic          i_in_set_key,
  input  logic [127:0]  i_in_data,
  input  logic          i_load,
  output logic          o_out_valid,
  output logic          o_out_set_key,
  output logic [127:0]  o_out_data,
  output logic [AW:0]   o_level,
  output logic          o_key_pending,
  output logic          o_overflow_err
);

  logic [128:0] r_mem [DEPTH];
  logic [AW:0]  r_rd_ptr;
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_key_cnt;
  logic         r_overflow;

  logic         w_empty;
  logic         w_full;
  logic         w_push;
  logic         w_pop;
  logic [128:0] w_head;
  logic         w_push_key;
  logic         w_pop_key;

  assign w_empty = (r_rd_ptr == r_wr_ptr);
  assign w_full  = (r_rd_ptr[AW-1:0] == r_wr_ptr[AW-1:0]) &&
                   (r_rd_ptr[AW] != r_wr_ptr[AW]);

  // in_ready ignores load: no push-on-full even if a pop happens in the same cycle.
  assign w_push = i_in_valid && !w_full && !i_flush;
  assign w_pop  = i_load && !w_empty && !i_flush;

  assign w_head     = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign w_push_key = w_push && i_in_set_key;
  assign w_pop_key  = w_pop && w_head[128];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {i_in_set_key, i_in_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_key_cnt  <= '0;
      r_overflow <= 1'b0;
    end else if (i_flush) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_key_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_key, w_pop_key})
        2'b10:   r_key_cnt <= r_key_cnt + 1'b1;
        2'b01:   r_key_cnt <= r_key_cnt - 1'b1;
        default: r_key_cnt <= r_key_cnt;
      endcase
      // Host ignored backpressure; the offered packet is dropped.
      if (i_in_valid && w_full) r_overflow <= 1'b1;
    end
  end

  assign o_in_ready     = !w_full;
  assign o_out_valid    = !w_empty;
  assign o_out_set_key  = w_head[128];
  assign o_out_data     = w_head[127:0];
  assign o_level        = r_wr_ptr - r_rd_ptr;
  assign o_key_pending  = (r_key_cnt != '0);
  assign o_overflow_err = r_overflow;

endmodule

// File: tb/tb_aes_input_fifo.sv
// Directed bench for aes_input_fifo: latency, hold, full/overflow, wraps, flush, async reset.
module tb_aes_input_fifo;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          in_set_key;
  logic [127:0]  in_data;
  logic          load;
  logic          out_valid;
  logic          out_set_key;
  logic [127:0]  out_data;
  logic [3:0]    level;
  logic          key_pending;
  logic          overflow_err;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] PKT_A  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] PKT_K  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] PKT_D1 = 128'h6bc1bee2_2e409f96_e93d7e11_7393172a;
  localparam logic [127:0] PKT_D2 = 128'hae2d8a57_1e03ac9c_9eb76fac_45af8e51;

  logic [128:0] q[$];
  logic         do_push;
  logic         do_pop;
  int           sent;
  int           rcvd;
  int           keys;

  aes_input_fifo #(.DEPTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_flush        (flush),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_set_key   (in_set_key),
    .i_in_data      (in_data),
    .i_load         (load),
    .o_out_valid    (out_valid),
    .o_out_set_key  (out_set_key),
    .o_out_data     (out_data),
    .o_level        (level),
    .o_key_pending  (key_pending),
    .o_overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},     128'(in_ready),     128'd1);
    check({tag, "_out_valid"},    128'(out_valid),    128'd0);
    check({tag, "_out_set_key"},  128'(out_set_key),  128'd0);
    check({tag, "_out_data"},     out_data,           128'd0);
    check({tag, "_level"},        128'(level),        128'd0);
    check({tag, "_key_pending"},  128'(key_pending),  128'd0);
    check({tag, "_overflow_err"}, 128'(overflow_err), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_set_key = 1'b0;
    in_data = '0; load = 1'b0;
    #23;
    check_reset_outputs("reset");
    step();
    rst_n = 1'b1;
    step();

    // Single packet through with load held high.
    in_valid = 1'b1; in_data = PKT_A; in_set_key = 1'b0; load = 1'b1;
    check("a_empty_before", 128'(out_valid), 128'd0);
    step();
    in_valid = 1'b0;
    check("a_valid", 128'(out_valid), 128'd1);
    check("a_data",  out_data, PKT_A);
    check("a_level", 128'(level), 128'd1);
    step();
    check("a_popped_valid", 128'(out_valid), 128'd0);
    check("a_popped_level", 128'(level), 128'd0);
    check("a_popped_data",  out_data, 128'd0);

    // Key then two blocks; hold D1 for an 11-cycle key expansion window.
    load = 1'b0;
    in_valid = 1'b1; in_set_key = 1'b1; in_data = PKT_K;
    step();
    check("k_key_pending", 128'(key_pending), 128'd1);
    in_set_key = 1'b0; in_data = PKT_D1;
    step();
    in_data = PKT_D2;
    step();
    in_valid = 1'b0;
    check("k_level3",   128'(level), 128'd3);
    check("k_head",     out_data, PKT_K);
    check("k_head_key", 128'(out_set_key), 128'd1);
    load = 1'b1;
    step();
    load = 1'b0;
    check("k_pop_pending", 128'(key_pending), 128'd0);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("hold_d1_%0d", i), out_data, PKT_D1);
      check($sformatf("hold_lvl_%0d", i), 128'(level), 128'd2);
      step();
    end
    load = 1'b1;
    step();
    check("d2_out", out_data, PKT_D2);
    step();
    load = 1'b0;
    check("d_drained", 128'(out_valid), 128'd0);

    // Fill to full, overflow attempt, then drain.
    in_valid = 1'b1; in_set_key = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_data = 128'hF00D_0000 + 128'(i);
      step();
    end
    check("full_level", 128'(level), 128'd8);
    check("full_ready", 128'(in_ready), 128'd0);
    check("full_ovf_clear", 128'(overflow_err), 128'd0);
    in_data = 128'hDEAD_BEEF;
    step();
    in_valid = 1'b0;
    check("ovf_set", 128'(overflow_err), 128'd1);
    check("ovf_level", 128'(level), 128'd8);
    load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d", i), out_data, 128'hF00D_0000 + 128'(i));
      step();
      if (i == 0) check("ready_after_pop", 128'(in_ready), 128'd1);
    end
    load = 1'b0;
    check("drain_empty", 128'(out_valid), 128'd0);
    check("ovf_sticky", 128'(overflow_err), 128'd1);

    // Random concurrent push/pop against a queue model; starts at pointer 12, ends at 32.
    sent = 0; rcvd = 0;
    for (int cyc = 0; cyc < 400 && rcvd < 20; cyc++) begin
      in_valid   = (sent < 20) && (q.size() < 8) && ($urandom_range(0, 1) == 1);
      in_data    = 128'hC0DE_0000 + 128'(sent);
      in_set_key = (sent % 3 == 0);
      load       = ($urandom_range(0, 1) == 1);
      do_push = in_valid && (q.size() < 8);
      do_pop  = load && (q.size() > 0);
      step();
      if (do_pop)  begin void'(q.pop_front()); rcvd++; end
      if (do_push) begin q.push_back({in_set_key, in_data}); sent++; end
      keys = 0;
      foreach (q[j]) if (q[j][128]) keys++;
      check("rnd_level", 128'(level), 128'(q.size()));
      check("rnd_key_pending", 128'(key_pending), 128'(keys != 0));
      if (q.size() > 0) begin
        check("rnd_data", out_data, q[0][127:0]);
        check("rnd_set_key", 128'(out_set_key), 128'(q[0][128]));
      end else begin
        check("rnd_empty", 128'(out_valid), 128'd0);
      end
    end
    in_valid = 1'b0; load = 1'b0;
    check("rnd_all_delivered", 128'(rcvd), 128'd20);

    // Flush with 5 entries while pushing and loading.
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 128'hF1F1_0000 + 128'(i);
      in_set_key = (i == 2);
      step();
    end
    check("pre_flush_level", 128'(level), 128'd5);
    check("pre_flush_key", 128'(key_pending), 128'd1);
    flush = 1'b1; in_data = 128'hBAD0; in_set_key = 1'b1; load = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; load = 1'b0;
    check_reset_outputs("flush");
    step();
    check("flush_push_discarded", 128'(level), 128'd0);

    // Asynchronous reset mid-stream with three entries stored.
    in_valid = 1'b1; in_set_key = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 128'hAB00 + 128'(i);
      step();
    end
    in_valid = 1'b0;
    check("pre_rst_level", 128'(level), 128'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    step();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = PKT_D1;
    step();
    in_valid = 1'b0;
    check("post_rst_valid", 128'(out_valid), 128'd1);
    check("post_rst_data", out_data, PKT_D1);
    check("post_rst_level", 128'(level), 128'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
